// File: rtl/pipeline_pause_ctrl_if.sv
// Hazard, memory-status and pipeline-enable bundle between the pipeline datapath
// and the central pause sequencer.
interface pipeline_pause_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             ID_EX_memread;
  logic [4:0]       ID_EX_rt;
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             IF_ID_uses_rt;
  logic             mem_busy;
  logic             wb_regwrite_in;
  logic             clear_stats;

  logic             pc_write;
  logic             IF_ID_write;
  logic             ID_EX_flush;
  logic             pipe_hold;
  logic             reg_write_pause;
  logic             pause_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] pause_cnt;
  logic [1:0]       state;

  modport master (
    output ID_EX_memread, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
           mem_busy, wb_regwrite_in, clear_stats,
    input  pc_write, IF_ID_write, ID_EX_flush, pipe_hold, reg_write_pause,
           pause_timeout, stall_cnt, pause_cnt, state
  );

  modport slave (
    input  ID_EX_memread, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
           mem_busy, wb_regwrite_in, clear_stats,
    output pc_write, IF_ID_write, ID_EX_flush, pipe_hold, reg_write_pause,
           pause_timeout, stall_cnt, pause_cnt, state
  );
endinterface

// File: rtl/pipeline_pause_ctrl.sv
// Stall/pause sequencer for the 5-stage pipeline: load-use bubbles, memory-busy
// freeze, and a write-back enable that lets a held MEM/WB instruction write once.
module pipeline_pause_ctrl #(
  parameter int MAX_PAUSE = 15,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_pause_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSE  = 2'd2,
    RESUME = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      MAX_LIMIT = 32'(MAX_PAUSE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             tmo_q, tmo_d;

  logic load_use;
  logic stall_inc, pause_start, pause_inc;
  logic pc_en, ifid_en, flush, hold, rwp;

  assign load_use = bus.ID_EX_memread & (bus.ID_EX_rt != 5'd0) &
                    ((bus.ID_EX_rt == bus.IF_ID_rs) |
                     (bus.IF_ID_uses_rt & (bus.ID_EX_rt == bus.IF_ID_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= '0;
      pcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      pcnt_q  <= pcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    flush       = 1'b0;
    hold        = 1'b0;
    rwp         = bus.wb_regwrite_in;
    stall_inc   = 1'b0;
    pause_start = 1'b0;
    pause_inc   = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.mem_busy) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          hold        = 1'b1;
          pause_start = 1'b1;
          state_d     = PAUSE;
        end else if (load_use) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          flush     = 1'b1;
          stall_inc = 1'b1;
        end
      end
      // MEM/WB already wrote on the entry cycle, so writes stay off until RUN.
      PAUSE: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        hold    = 1'b1;
        rwp     = 1'b0;
        if (bus.mem_busy) begin
          pause_inc = 1'b1;
        end else begin
          state_d = RESUME;
        end
      end
      RESUME: begin
        rwp     = 1'b0;
        state_d = RUN;
        if (bus.mem_busy) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          hold        = 1'b1;
          pause_start = 1'b1;
          state_d     = PAUSE;
        end else if (load_use) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          flush     = 1'b1;
          stall_inc = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst_n) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      flush   = 1'b1;
      hold    = 1'b0;
      rwp     = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    pcnt_d  = pcnt_q;
    tmo_d   = tmo_q;

    if (stall_inc && (stall_q != CNT_SAT)) begin
      stall_d = stall_q + CNT_ONE;
    end

    if (pause_start) begin
      pcnt_d = CNT_ONE;
    end else if (pause_inc && (pcnt_q != CNT_SAT)) begin
      pcnt_d = pcnt_q + CNT_ONE;
    end

    if ((pause_start || pause_inc) && (32'(pcnt_d) >= MAX_LIMIT)) begin
      tmo_d = 1'b1;
    end

    // Clearing wins over any increment landing on the same edge.
    if (bus.clear_stats) begin
      stall_d = '0;
      pcnt_d  = '0;
      tmo_d   = 1'b0;
    end
  end

  assign bus.pc_write        = pc_en;
  assign bus.IF_ID_write     = ifid_en;
  assign bus.ID_EX_flush     = flush;
  assign bus.pipe_hold       = hold;
  assign bus.reg_write_pause = rwp;
  assign bus.pause_timeout   = tmo_q;
  assign bus.stall_cnt       = stall_q;
  assign bus.pause_cnt       = pcnt_q;
  assign bus.state           = state_q;

endmodule

// File: doc/pipeline_pause_ctrl.md
Name: pipeline_pause_ctrl

Overview:
- Central stall/pause sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards and inserts a one-cycle bubble.
- Freezes the whole pipeline while external memory is busy.
- Produces the gated write-back enable (reg_write_pause) consumed by the register-file write path, so a held MEM/WB instruction writes exactly once.

Parameters:
- MAX_PAUSE, 15: pause length in cycles at which pause_timeout sets.
- CNT_W, 8: width of the saturating stall and pause statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ID_EX_memread  input  1  instruction in EX is a load.
- ID_EX_rt  input  5  load destination register.
- IF_ID_rs  input  5  rs of instruction in ID.
- IF_ID_rt  input  5  rt of instruction in ID.
- IF_ID_uses_rt  input  1  ID instruction reads rt.
- mem_busy  input  1  data/instruction memory not ready; pipeline must freeze.
- wb_regwrite_in  input  1  regwrite from the MEM/WB register.
- clear_stats  input  1  synchronous clear of counters and timeout flag.
- pc_write  output  1  PC load enable.
- IF_ID_write  output  1  IF/ID load enable.
- ID_EX_flush  output  1  zero control bits entering ID/EX (bubble).
- pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB.
- reg_write_pause  output  1  gated regwrite to register file.
- pause_timeout  output  1  sticky; pause reached MAX_PAUSE.
- stall_cnt  output  CNT_W  load-use bubbles inserted, saturating.
- pause_cnt  output  CNT_W  cycles in current/last pause, saturating.
- state  output  2  RUN=0, PAUSE=2, RESUME=3 (1 unused).

Behaviour:
- Clocking and reset:
  - State, counters and flag are registered.
  - Enable outputs are combinational from the registered state and current inputs (same-cycle stall).
- While rst_n=0:
  - state=RUN, counters=0, pause_timeout=0.
  - Outputs forced: pc_write=0, IF_ID_write=0, ID_EX_flush=1, pipe_hold=0, reg_write_pause=0.
- Reset asserted mid-pause aborts immediately to RUN.
- Load-use condition: load_use = ID_EX_memread & (ID_EX_rt!=0) & ((ID_EX_rt==IF_ID_rs) | (IF_ID_uses_rt & ID_EX_rt==IF_ID_rt)).
- RUN:
  - If mem_busy=1 (takes priority over load_use):
    - pc_write=0, IF_ID_write=0, pipe_hold=1, ID_EX_flush=0.
    - reg_write_pause=wb_regwrite_in, so the held instruction writes once now.
    - pause_cnt<=1; next state PAUSE.
  - Else if load_use:
    - pc_write=0, IF_ID_write=0, ID_EX_flush=1, pipe_hold=0.
    - reg_write_pause=wb_regwrite_in.
    - stall_cnt++; stays in RUN.
  - Else all enables=1, flush=0, hold=0, reg_write_pause=wb_regwrite_in.
- PAUSE:
  - pc_write=0, IF_ID_write=0, pipe_hold=1, ID_EX_flush=0, reg_write_pause=0 (duplicate write suppressed).
  - pause_cnt++ (saturating).
  - When pause_cnt reaches MAX_PAUSE, pause_timeout<=1 (sticky).
  - mem_busy=0 → next RESUME; else stays in PAUSE.
- RESUME, one cycle:
  - pipe_hold=0.
  - reg_write_pause=0, because MEM/WB still holds the already-written instruction.
  - mem_busy=1 → outputs as PAUSE, pause_cnt<=1, next PAUSE.
  - Else load_use → bubble as in RUN, stall_cnt++.
  - Else all enables=1.
  - Next state RUN.
- clear_stats:
  - Zeroes stall_cnt, pause_cnt and pause_timeout next edge.
  - Overrides any same-cycle increment.
  - Does not change state.
- Counter saturation: counters saturate at 2^CNT_W-1; no wrap.

Test Plan:
- Reset, then release rst_n with all inputs 0 → state=0, pc_write=1, IF_ID_write=1, ID_EX_flush=0, reg_write_pause follows wb_regwrite_in.
- Load-use: ID_EX_memread=1, ID_EX_rt=5, IF_ID_rs=5 for one cycle → that cycle pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_cnt=1 next cycle. Repeat with ID_EX_rt=0 → no stall.
- Pause: wb_regwrite_in=1 held, mem_busy=1 for 4 cycles → reg_write_pause=1 only in the first cycle, pipe_hold=1 for 4 cycles. Then RESUME with reg_write_pause=0, then RUN; pause_cnt=4.
- Simultaneous mem_busy=1 and load_use in RUN → PAUSE taken, ID_EX_flush=0, stall_cnt unchanged.
- mem_busy held 20 cycles, MAX_PAUSE=15 → pause_timeout rises on the 15th pause cycle and stays 1 after release until clear_stats pulse.
- mem_busy reasserted in RESUME → back to PAUSE with reg_write_pause=0 throughout and pause_cnt restarting at 1. Separately, rst_n pulsed low mid-pause → state=RUN immediately.
